// File: rtl/uart_pkg.sv
// Shared framing constants for the second-count serial link (transmitter and receiver).
package uart_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int   BAUD_DIV_DEFAULT = 1042;
  localparam int   DATA_BITS        = 8;
  localparam logic STOP_LEVEL       = 1'b1;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, reset to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= RST_VAL;
      q       <= RST_VAL;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end
endmodule

// File: rtl/time_receiver.sv
// 8-N-1 receiver for the second-count link: recovers bytes, latches the second value,
// and flags framing and sequence errors.
module time_receiver
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
  parameter int SEC_WRAP = 60
) (
  input  logic       clk_10M,
  input  logic       rst,
  input  logic       data_from_master,
  output logic [7:0] time_second,
  output logic       data_valid,
  output logic       frame_err,
  output logic       seq_err,
  output logic [1:0] rx_state,
  output logic [3:0] bit_num
);
  localparam int               CNT_W     = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]       LAST_BIT  = 4'(DATA_BITS - 1);

  logic             line_sync, line_hist, fall;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             done_d, stop_ok_d;
  logic             vld_p0, stop_ok_p0;
  logic             have_ref;

  // prev+1 is formed at 9 bits so prev=255 never aliases to 0
  function automatic logic seq_break(input logic [7:0] prev, input logic [7:0] rx);
    logic [8:0] expected;
    expected = ({1'b0, prev} == 9'(SEC_WRAP - 1)) ? 9'd0 : {1'b0, prev} + 9'd1;
    return ({1'b0, rx} != expected) || (int'(rx) >= SEC_WRAP);
  endfunction

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk_10M),
    .rst_n (rst),
    .d     (data_from_master),
    .q     (line_sync)
  );

  assign fall     = line_hist & ~line_sync;
  assign rx_state = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_num;
    shift_d   = shift_q;
    done_d    = 1'b0;
    stop_ok_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!line_sync) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {line_sync, shift_q[7:1]};
          bit_d   = bit_num + 4'd1;
          if (bit_num == LAST_BIT) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          state_d   = IDLE;
          done_d    = 1'b1;
          stop_ok_d = (line_sync == STOP_LEVEL);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // p0: synchronizer history, FSM state and stop-bit verdict
  always_ff @(posedge clk_10M or negedge rst) begin
    if (!rst) begin
      line_hist  <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_num    <= '0;
      shift_q    <= '0;
      vld_p0     <= 1'b0;
      stop_ok_p0 <= 1'b0;
    end else begin
      line_hist  <= line_sync;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_num    <= bit_d;
      shift_q    <= shift_d;
      vld_p0     <= done_d;
      stop_ok_p0 <= stop_ok_d;
    end
  end

  // p1: registered one-cycle result pulses and sequence tracking
  always_ff @(posedge clk_10M or negedge rst) begin
    if (!rst) begin
      time_second <= '0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      seq_err     <= 1'b0;
      have_ref    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      seq_err    <= 1'b0;
      if (vld_p0) begin
        if (stop_ok_p0) begin
          time_second <= shift_q;
          data_valid  <= 1'b1;
          seq_err     <= have_ref && seq_break(time_second, shift_q);
          have_ref    <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_time_receiver.sv
// Scoreboard bench for time_receiver: frames are modelled at byte level, expected
// results are queued at frame start and matched by an independent output monitor.
module tb_time_receiver;
  localparam int BD   = 40;
  localparam int WRAP = 60;
  localparam int LAT  = 3 + BD / 2 + 9 * BD + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] val;
    bit         seq;
    longint     due;
  } exp_t;

  logic       clk_10M;
  logic       rst;
  logic       data_from_master;
  logic [7:0] time_second;
  logic       data_valid, frame_err, seq_err;
  logic [1:0] rx_state;
  logic [3:0] bit_num;

  exp_t       exp_q[$];
  exp_t       mon_e;
  longint     cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  bit         have_ref = 0;
  logic [7:0] prev = 8'd0;

  time_receiver #(.BAUD_DIV(BD), .SEC_WRAP(WRAP)) dut (
    .clk_10M          (clk_10M),
    .rst              (rst),
    .data_from_master (data_from_master),
    .time_second      (time_second),
    .data_valid       (data_valid),
    .frame_err        (frame_err),
    .seq_err          (seq_err),
    .rx_state         (rx_state),
    .bit_num          (bit_num)
  );

  initial begin
    clk_10M = 1'b0;
    forever #50 clk_10M = ~clk_10M;
  end

  always @(posedge clk_10M) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_10M);
    #1;
  endtask

  // Byte-level reference: the expected successor of WRAP-1 is 0, otherwise prev+1
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    exp_t e;
    int   nxt;
    step(1);
    data_from_master = 1'b0;
    e.due    = cyc + LAT;
    e.is_err = !stop_ok;
    if (stop_ok) begin
      nxt      = (int'(prev) == WRAP - 1) ? 0 : int'(prev) + 1;
      e.val    = b;
      e.seq    = have_ref && ((int'(b) != nxt) || (int'(b) >= WRAP));
      prev     = b;
      have_ref = 1'b1;
    end else begin
      e.val = prev;
      e.seq = 1'b0;
    end
    exp_q.push_back(e);
    step(BD - 1);
    for (int i = 0; i < 8; i++) begin
      data_from_master = b[i];
      step(BD);
    end
    data_from_master = stop_ok;
    step(BD);
  endtask

  task automatic glitch(input int len);
    step(1);
    data_from_master = 1'b0;
    step(len);
    data_from_master = 1'b1;
    step(2 * BD);
    check("glitch_idle_state", rx_state, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_time_second"}, time_second, 0);
    check({tag, "_data_valid"}, data_valid, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_seq_err"}, seq_err, 0);
    check({tag, "_rx_state"}, rx_state, 0);
    check({tag, "_bit_num"}, bit_num, 0);
  endtask

  always @(negedge clk_10M) begin
    if (rst) begin
      if (data_valid || frame_err) begin
        check("dv_fe_exclusive", data_valid & frame_err, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse_queue", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_kind_frame_err", frame_err, mon_e.is_err);
          check("time_second", time_second, mon_e.val);
          check("seq_err", seq_err, mon_e.seq);
          check("latency_cycle", cyc, mon_e.due);
        end
      end
      if (seq_err) check("seq_err_with_valid", data_valid, 1);
    end
  end

  initial begin
    int bad;
    int found;
    int r;
    logic [7:0] b;
    rst = 1'b0;
    data_from_master = 1'b1;
    repeat (3) @(negedge clk_10M);
    check_reset_outputs("reset");
    step(1);
    rst = 1'b1;

    bad = 0;
    repeat (2000) begin
      @(negedge clk_10M);
      if (time_second != 0 || data_valid || frame_err || seq_err || rx_state != 0 || bit_num != 0)
        bad++;
    end
    check("idle_quiet", bad, 0);

    send_frame(8'h05, 1'b1);
    send_frame(8'h06, 1'b1);
    send_frame(8'h3B, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'h02, 1'b1);

    send_frame(8'h10, 1'b0);
    step(5 * BD);
    check("break_idle_state", rx_state, 0);
    data_from_master = 1'b1;
    step(BD);
    send_frame(8'h11, 1'b1);

    glitch(BD / 4);
    send_frame(8'h20, 1'b1);

    step(BD);
    data_from_master = 1'b0;
    found = 0;
    for (int k = 0; k < 20 * BD; k++) begin
      @(negedge clk_10M);
      if (rx_state == 2'd2 && bit_num == 4'd4) begin
        found = 1;
        break;
      end
    end
    check("reach_data_bit4", found, 1);
    step(1);
    rst = 1'b0;
    data_from_master = 1'b1;
    have_ref = 1'b0;
    prev = 8'd0;
    repeat (10) @(negedge clk_10M);
    check_reset_outputs("midframe_reset");
    step(1);
    rst = 1'b1;
    step(BD);
    send_frame(8'h07, 1'b1);

    for (int n = 0; n < 60; n++) begin
      step($urandom_range(1, BD));
      r = $urandom_range(0, 99);
      b = 8'($urandom_range(0, 255));
      if (r < 8) begin
        glitch($urandom_range(1, BD / 4));
      end else if (r < 18) begin
        send_frame(b, 1'b0);
        step($urandom_range(0, 3 * BD));
        data_from_master = 1'b1;
        step(BD);
      end else if (r < 70) begin
        if (have_ref) b = (int'(prev) == WRAP - 1) ? 8'd0 : prev + 8'd1;
        send_frame(b, 1'b1);
      end else begin
        if (r < 85) b = 8'($urandom_range(0, WRAP - 1));
        send_frame(b, 1'b1);
      end
    end

    for (int k = 0; k < 2 * LAT && exp_q.size() != 0; k++) @(negedge clk_10M);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/time_receiver.md
Name: time_receiver

Overview:
- Slave-end serial receiver for the second-count link driven by `transmitter`.
- Recovers 8-N-1 asynchronous frames (idle high, start 0, 8 data bits LSB first, stop 1) from the serial line on the 10 MHz system clock.
- Latches the received second value and flags framing and sequence errors.
- Sits on the slave board, directly behind the pin carrying `data_to_slave`.

Parameters:
- BAUD_DIV, 1042: clk_10M cycles per bit (10 MHz / 9600 baud, rounded). Must be >= 4.
- SEC_WRAP, 60: modulus of the second counter; the expected successor of SEC_WRAP-1 is 0.

Ports:
- clk_10M  in  1  system clock, 10 MHz
- rst  in  1  asynchronous, active-low reset
- data_from_master  in  1  serial line, asynchronous to clk_10M, idles high
- time_second  out  8  last correctly framed byte
- data_valid  out  1  one-cycle pulse when time_second updates
- frame_err  out  1  one-cycle pulse on a bad stop bit
- seq_err  out  1  one-cycle pulse, coincident with data_valid, when the value breaks sequence
- rx_state  out  2  current FSM state (debug)
- bit_num  out  4  data bits received in current frame, 0..8 (debug)

Behaviour:
- Reset (rst=0, async): time_second=0, data_valid=0, frame_err=0, seq_err=0, rx_state=IDLE, bit_num=0, baud counter=0, shift register=0, have_ref=0, synchronizer flops=1.
- Input conditioning:
  - Two-flop synchronizer, then a one-flop history stage.
  - A falling edge is synced=0 while history=1.
- States (2-bit encoding): IDLE=0, START=1, DATA=2, STOP=3.
- IDLE:
  - Counter held at 0.
  - A falling edge moves the FSM to START.
- START:
  - Count to BAUD_DIV/2-1 (integer division), then sample the line.
  - Sample 0: go to DATA, counter=0, bit_num=0.
  - Sample 1: glitch. Return to IDLE with no error.
- DATA:
  - Every BAUD_DIV cycles (counter reaches BAUD_DIV-1), sample the line into shift_reg MSB and shift right, so the first bit received ends at bit 0.
  - bit_num increments on each sample.
  - After the 8th sample go to STOP.
- STOP: sample after BAUD_DIV cycles.
  - Sample 1:
    - time_second <= shift_reg and data_valid=1 on the next cycle.
    - The sequence check runs (see below).
  - Sample 0:
    - frame_err=1 on the next cycle; time_second unchanged.
  - Both cases return to IDLE.
  - A line held low (break) cannot re-arm the receiver, because re-arming needs a new high-to-low edge.
- Sequence check (valid frames only):
  - have_ref=0: no seq_err, then set have_ref=1.
  - Otherwise expected = (prev == SEC_WRAP-1) ? 0 : prev+1.
  - seq_err=1 if received != expected or received >= SEC_WRAP.
  - time_second updates regardless.
  - frame_err does not clear have_ref.
- Latency:
  - data_valid rises 2 (sync) + 1 (edge) + BAUD_DIV/2 + 9*BAUD_DIV + 1 cycles after the line falls. This is 9903 cycles at the defaults.
- Pulses: all pulse outputs are registered and high for exactly one cycle. data_valid and frame_err are never high together.
- Mid-operation: a falling edge during START, DATA or STOP is ignored. Only the FSM timing governs sampling.
- Reset mid-frame aborts immediately. The partial byte is discarded and the next frame is received normally.
- Width rules:
  - Baud counter width is $clog2(BAUD_DIV).
  - The comparison prev+1 is computed at 9 bits, so prev=255 does not wrap to 0.

Decomposition:
- Shared package (uart_pkg) holds:
  - The state encoding constants IDLE/START/DATA/STOP.
  - The default BAUD_DIV.
  - Frame constants DATA_BITS=8 and STOP_LEVEL=1.
  - The transmitter uses the same package.
- One sub-module, sync_2ff: 1-bit two-flop synchronizer with reset value parameter RST_VAL=1. It is reusable for other asynchronous slave inputs.

Test Plan:
- Reset, line idle high for 20000 cycles:
  - All outputs stay at their reset values.
  - rx_state=0 throughout.
- Send frame 0x05, then frame 0x06:
  - time_second=0x05 then 0x06.
  - data_valid pulses once per frame, 9903 cycles after each start edge.
  - seq_err=0 on both frames.
- Send 0x3B (59), then 0x00:
  - No seq_err, because the value wraps.
  - Then send 0x02: seq_err pulses together with data_valid, and time_second=0x02.
- Send 0x10 with the stop bit forced 0:
  - frame_err pulses once; data_valid=0; time_second keeps its prior value.
  - Hold the line low for 5 bit times: no further activity.
  - Release the line and send 0x11: valid frame received.
- Pulse the line low for 200 cycles, shorter than BAUD_DIV/2:
  - The FSM returns to IDLE with no error pulse.
  - A following 0x20 frame is received correctly.
- Assert rst for 10 cycles during DATA at bit_num=4:
  - Outputs return to their reset values.
  - The next full 0x07 frame yields data_valid with seq_err=0, because have_ref was cleared.
